lcd_text_formatter: RTL

- Upstream stage of `lcd_driver`.
- Captures two 32-bit unsigned counts, for example cache hit and miss totals from the LeakyRand experiment logic.
- Converts each count to a 10-digit decimal string with a sequential double-dabble (shift-add-3) engine.
- Packs each result with a 4-character label into a 16-character ASCII line, presents `line1`/`line2` to the driver, and raises `output_ready` only once both lines are stable.

---
 rtl/lcd_text_formatter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lcd_text_formatter.sv
// lcd_text_formatter
//   Captures two 32-bit unsigned counts and converts both to 10-digit decimal
//   in parallel, using a sequential double-dabble (shift-add-3) engine that
//   handles one bit per cycle. Each result is packed behind a 4-character
//   label into a 16-character ASCII line for lcd_driver.
//
//   Line layout: cols 0-3 label, col 4 ':', col 5 ' ', cols 6-15 digits
//   (most significant digit first).
//
//   Optional feature: define LCD_FMT_ZERO_BLANK_EN to blank leading zeros in
//   cols 6-14. Col 15 always shows a digit.
//
// Parameters
//   LABEL1, LABEL2 : 4 ASCII characters, first character in bits [31:24]
// Ports
//   clk            : clock, all logic on the rising edge
//   rst_n          : synchronous active-low reset
//   load           : one-cycle request to capture value1/value2
//                    (honoured only in IDLE and SHOW)
//   value1, value2 : unsigned counts for line 1 and line 2
//   busy           : high in CONV and PACK
//   output_ready   : lines valid; drives the lcd_driver enable
//   line1, line2   : [0:127], character k at bits [8k:8k+7] (bit 8k is the MSB)
//
// Reset sets the state to IDLE, clears the datapath and fills both lines
// with spaces.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for the first load, lines show spaces
// CONV  | 32 shift-add-3 iterations, one per cycle (bit_cnt 0..31)
// PACK  | register line1/line2 from the BCD results, raise output_ready
// SHOW  | hold the lines; a load starts a new conversion

module lcd_text_formatter #(
  parameter logic [31:0] LABEL1 = 32'h4849_5420,
  parameter logic [31:0] LABEL2 = 32'h4D49_5353
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [31:0]   value1,
  input  logic [31:0]   value2,
  output logic          busy,
  output logic          output_ready,
  output logic [0:127]  line1,
  output logic [0:127]  line2
);

  typedef enum logic [1:0] {IDLE, CONV, PACK, SHOW} state_t;

  localparam logic [0:127] BLANK_LINE = {16{8'h20}};

  state_t       state;
  logic [31:0]  val1_q, val2_q;
  logic [39:0]  bcd1_q, bcd2_q;
  logic [39:0]  bcd1_adj, bcd2_adj;
  logic [4:0]   bit_cnt;

  // Add 3 to every nibble >= 5 before the shift. This keeps each nibble a
  // valid BCD digit after it doubles.
  function automatic logic [39:0] add3(input logic [39:0] b);
    logic [39:0] r;
    logic [3:0]  nib;
    r = b;
    for (int i = 0; i < 10; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd5)
        r[4*i +: 4] = nib + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [0:127] pack_line(input logic [31:0] label,
                                             input logic [39:0] bcd);
    logic [0:127] l;
    logic [3:0]   d;
`ifdef LCD_FMT_ZERO_BLANK_EN
    logic         lead;
    lead = 1'b1;
`endif
    l = BLANK_LINE;
    l[0:31]  = label;
    l[32:39] = 8'h3A;
    l[40:47] = 8'h20;
    for (int i = 0; i < 10; i++) begin
      d = bcd[39-4*i -: 4];
`ifdef LCD_FMT_ZERO_BLANK_EN
      // Blank only while still inside the leading zeros. The last column
      // always prints, so a value of 0 shows a single '0'.
      if (lead && (d == 4'd0) && (i < 9)) begin
        l[48+8*i +: 8] = 8'h20;
      end else begin
        lead = 1'b0;
        l[48+8*i +: 8] = {4'h3, d};
      end
`else
      l[48+8*i +: 8] = {4'h3, d};
`endif
    end
    return l;
  endfunction

  assign bcd1_adj = add3(bcd1_q);
  assign bcd2_adj = add3(bcd2_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      val1_q       <= '0;
      val2_q       <= '0;
      bcd1_q       <= '0;
      bcd2_q       <= '0;
      bit_cnt      <= '0;
      busy         <= 1'b0;
      output_ready <= 1'b0;
      line1        <= BLANK_LINE;
      line2        <= BLANK_LINE;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            val1_q  <= value1;
            val2_q  <= value2;
            bcd1_q  <= '0;
            bcd2_q  <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd1_q  <= {bcd1_adj[38:0], val1_q[31]};
          bcd2_q  <= {bcd2_adj[38:0], val2_q[31]};
          val1_q  <= {val1_q[30:0], 1'b0};
          val2_q  <= {val2_q[30:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31)
            state <= PACK;
        end
        PACK: begin
          line1        <= pack_line(LABEL1, bcd1_q);
          line2        <= pack_line(LABEL2, bcd2_q);
          output_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= SHOW;
        end
        SHOW: begin
          // The old lines stay up until the next PACK. Only the ready flag
          // drops, so lcd_driver sees a low edge.
          if (load) begin
            val1_q       <= value1;
            val2_q       <= value2;
            bcd1_q       <= '0;
            bcd2_q       <= '0;
            bit_cnt      <= '0;
            output_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= CONV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
